matrix_3x3_gen: RTL and testbench

MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

---
 rtl/median_pkg.sv | 17 +
 rtl/line_buf.sv | 26 ++
 rtl/matrix_3x3_gen.sv | 110 +++++++++++
 tb/tb_matrix_3x3_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median path: default pixel width, frame size
// and the packed three-pixel window row consumed by the downstream sorters.
package median_pkg;

   localparam int PIX_DW    = 8;
   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   // One window row, {col c-2, c-1, c}; MSB slot feeds sorter data1.
   typedef logic [3*PIX_DW-1:0] pix_row_t;

   // Position is inside the emitting region (no border padding).
   function automatic logic in_window(input int row, input int col);
      return (row >= 2) && (col >= 2);
   endfunction

endpackage

// File: rtl/line_buf.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Reads return the contents from before a same-edge write. No reset on the array.
module line_buf #(
   parameter int DEPTH = 640,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Storage write and registered read-before-write read
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Raster-order 3x3 neighbourhood generator: two line buffers plus three row
// shift registers, emitting one registered window per interior pixel.
module matrix_3x3_gen
   import median_pkg::*;
#(
   parameter int DW    = PIX_DW,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pix_valid,
   input  logic [DW-1:0]   pix_data,
   input  logic            frame_start,
   output logic            win_valid,
   output logic [3*DW-1:0] win_row1,
   output logic [3*DW-1:0] win_row2,
   output logic [3*DW-1:0] win_row3
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]   col_cnt_r, col_pos_s, col_nxt_s;
   logic [RW-1:0]   row_cnt_r, row_pos_s, row_nxt_s;
   logic [DW-1:0]   l1_old_s, l2_old_s;
   logic            win_valid_r;
   logic [3*DW-1:0] win_row1_r, win_row2_r, win_row3_r;

   // Position of the pixel on the bus and the position the next one will take
   always_comb begin
      col_pos_s = col_cnt_r;
      row_pos_s = row_cnt_r;
      col_nxt_s = col_cnt_r;
      row_nxt_s = row_cnt_r;
      if (pix_valid && frame_start) begin
         col_pos_s = {CW{1'b0}};
         row_pos_s = {RW{1'b0}};
      end else begin
         col_pos_s = col_cnt_r;
         row_pos_s = row_cnt_r;
      end
      if (pix_valid) begin
         if (col_pos_s == COL_LAST) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = (row_pos_s == ROW_LAST) ? {RW{1'b0}} : row_pos_s + RW'(1);
         end else begin
            col_nxt_s = col_pos_s + CW'(1);
            row_nxt_s = row_pos_s;
         end
      end else begin
         col_nxt_s = col_cnt_r;
         row_nxt_s = row_cnt_r;
      end
   end

   // Reads are issued one cycle early at the next column so that the old line
   // data is already on rd_data when the pixel arrives. A frame_start jump
   // mispredicts only on line 0, whose buffer reads never reach a valid window.
   line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_l1 (
      .clk     (clk),
      .we      (pix_valid),
      .wr_addr (col_pos_s),
      .wr_data (pix_data),
      .rd_addr (col_nxt_s),
      .rd_data (l1_old_s)
   );

   line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_l2 (
      .clk     (clk),
      .we      (pix_valid),
      .wr_addr (col_pos_s),
      .wr_data (l1_old_s),
      .rd_addr (col_nxt_s),
      .rd_data (l2_old_s)
   );

   // Counters, window shift registers and the valid pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_cnt_r   <= {CW{1'b0}};
         row_cnt_r   <= {RW{1'b0}};
         win_valid_r <= 1'b0;
         win_row1_r  <= {(3*DW){1'b0}};
         win_row2_r  <= {(3*DW){1'b0}};
         win_row3_r  <= {(3*DW){1'b0}};
      end else begin
         col_cnt_r   <= col_nxt_s;
         row_cnt_r   <= row_nxt_s;
         win_valid_r <= pix_valid && in_window(int'(row_pos_s), int'(col_pos_s));
         if (pix_valid) begin
            win_row1_r <= {win_row1_r[2*DW-1:0], l2_old_s};
            win_row2_r <= {win_row2_r[2*DW-1:0], l1_old_s};
            win_row3_r <= {win_row3_r[2*DW-1:0], pix_data};
         end else begin
            win_row1_r <= win_row1_r;
            win_row2_r <= win_row2_r;
            win_row3_r <= win_row3_r;
         end
      end
   end

   assign win_valid = win_valid_r;
   assign win_row1  = win_row1_r;
   assign win_row2  = win_row2_r;
   assign win_row3  = win_row3_r;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Randomised bench for matrix_3x3_gen (5x4 frames): a position/image model
// predicts every window; idle cycles must leave the outputs untouched.
module tb_matrix_3x3_gen;
   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pix_valid;
   logic [DW-1:0]   pix_data;
   logic            frame_start;
   logic            win_valid;
   logic [3*DW-1:0] win_row1, win_row2, win_row3;

   int n_tests = 0;
   int n_fail  = 0;

   matrix_3x3_gen #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .frame_start (frame_start),
      .win_valid   (win_valid),
      .win_row1    (win_row1),
      .win_row2    (win_row2),
      .win_row3    (win_row3)
   );

   always #5 clk = ~clk;

   // Reference model: image of the frame in progress and expected windows
   logic [7:0]  img [H][W];
   logic [71:0] exp_q [$];
   int          mr = 0, mc = 0;
   int          win_seen = 0;

   task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_pix(input logic [7:0] v, input logic fs);
      if (fs) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = v;
      if (mr >= 2 && mc >= 2)
         exp_q.push_back({img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                          img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                          img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]});
      mc++;
      if (mc == W) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end
   endtask

   // Called at posedge+1; leaves pix_valid low at posedge+1
   task automatic drive_pix(input logic [7:0] v, input logic fs, input int gap);
      for (int g = 0; g < gap; g++) begin
         pix_valid   = 1'b0;
         pix_data    = 8'($urandom);
         frame_start = 1'($urandom);
         @(posedge clk); #1;
      end
      pix_valid   = 1'b1;
      pix_data    = v;
      frame_start = fs;
      model_pix(v, fs);
      @(posedge clk); #1;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   // Send a frame up to (but excluding) position (stop_r, stop_c)
   task automatic send_frame(input logic [7:0] base, input int gap_max, input logic fs,
                             input int stop_r, input int stop_c);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (r * W + c < stop_r * W + stop_c)
               drive_pix(base + 8'(r * 16 + c), fs && r == 0 && c == 0,
                         (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
   endtask

   task automatic idle(input int n);
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_windows(input string tag, input int start, input int n);
      idle(4);
      check_val({tag, "_count"}, 96'(win_seen - start), 96'(n));
      check_val({tag, "_left"}, 96'(exp_q.size()), 96'd0);
   endtask

   // Monitor: compare windows, and require idle cycles to hold outputs
   logic        acc_q = 1'b0, rst_q = 1'b0;
   logic [71:0] prev_rows = 72'd0;
   always @(posedge clk) begin
      acc_q = pix_valid;
      rst_q = rst_n;
   end
   always @(negedge clk) begin
      if (win_valid === 1'b1) begin
         win_seen++;
         if (exp_q.size() == 0) begin
            check_val("spurious_win", 96'(win_valid), 96'd0);
         end else begin
            check_val("window", 96'({win_row1, win_row2, win_row3}), 96'(exp_q.pop_front()));
         end
      end
      if (rst_q && !acc_q) begin
         check_val("hold_rows", 96'({win_row1, win_row2, win_row3}), 96'(prev_rows));
         check_val("hold_valid", 96'(win_valid), 96'd0);
      end
      prev_rows = {win_row1, win_row2, win_row3};
   end

   initial begin
      int s;
      rst_n       = 1'b0;
      pix_valid   = 1'b0;
      pix_data    = 8'd0;
      frame_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_valid", 96'(win_valid), 96'd0);
      check_val("reset_rows", 96'({win_row1, win_row2, win_row3}), 96'd0);
      rst_n = 1'b1;
      idle(2);

      s = win_seen;
      send_frame(8'h00, 0, 1'b1, H, 0);
      expect_windows("continuous", s, 6);
      check_val("last_window", 96'({win_row1, win_row2, win_row3}),
                96'(72'h12_13_14_22_23_24_32_33_34));

      s = win_seen;
      send_frame(8'h00, 5, 1'b1, H, 0);
      expect_windows("gaps", s, 6);

      s = win_seen;
      send_frame(8'h00, 2, 1'b1, 2, 3);
      send_frame(8'h40, 2, 1'b1, H, 0);
      expect_windows("restart", s, 7);

      s = win_seen;
      send_frame(8'h00, 1, 1'b1, 2, 4);
      idle(1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_val("midreset_valid", 96'(win_valid), 96'd0);
      check_val("midreset_rows", 96'({win_row1, win_row2, win_row3}), 96'd0);
      mr = 0;
      mc = 0;
      send_frame(8'h60, 3, 1'b0, H, 0);
      expect_windows("after_reset", s, 8);

      s = win_seen;
      send_frame(8'h00, 0, 1'b1, H, 0);
      send_frame(8'h80, 0, 1'b1, H, 0);
      expect_windows("back_to_back", s, 12);

      s = win_seen;
      for (int f = 0; f < 3; f++)
         send_frame(8'($urandom), 3, 1'($urandom), H, 0);
      expect_windows("random_frames", s, 18);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
